gshare_predictor: RTL and testbench

Parametrised direction predictor for conditional branches, sitting between IF (query) and the RoB (commit-time training). It holds a PC-indexed table of saturating counters, XOR-folded with a speculative global history register (gshare). Setting HIST_W = 0 degenerates it to a per-PC bimodal table. It exports the history snapshot used for each prediction so the RoB can train the exact entry that predicted and repair history on a mispredict.

---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_pht.sv | 35 +++
 rtl/gshare_predictor.sv | 78 +++++++
 tb/tb_gshare_predictor.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: counter reset value, saturating
// step, and the PC/history index fold used by both query and update paths.
package bp_pkg;

    localparam int CNT_W_MAX = 4;

    // Weakly-taken midpoint for a counter of width cnt_w.
    function automatic logic [CNT_W_MAX-1:0] cnt_rst(input int cnt_w);
        return CNT_W_MAX'(1 << (cnt_w - 1));
    endfunction

    function automatic logic [CNT_W_MAX-1:0] sat_step(
        input logic [CNT_W_MAX-1:0] cnt,
        input logic                 dir,
        input int                   cnt_w
    );
        logic [CNT_W_MAX-1:0] w_max;
        w_max = CNT_W_MAX'((1 << cnt_w) - 1);
        if (dir)
            return (cnt == w_max) ? cnt : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

    // PC bit 0 is dropped so 2-byte aligned branches get their own entry.
    function automatic logic [31:0] fold_idx(
        input logic [31:0] pc,
        input logic [31:0] hist,
        input int          idx_w
    );
        logic [31:0] w_mask;
        w_mask = (32'd1 << idx_w) - 32'd1;
        return ((pc >> 1) ^ hist) & w_mask;
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: async read port plus one synchronous saturating
// read-modify-write port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CNT_W   = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [CNT_W-1:0]   o_rd_cnt,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic               i_wr_dir
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [CNT_W-1:0] r_pht [DEPTH];
    logic [CNT_W-1:0] w_next;

    assign o_rd_cnt = r_pht[i_rd_idx];
    assign w_next   = CNT_W'(sat_step(CNT_W_MAX'(r_pht[i_wr_idx]), i_wr_dir, CNT_W));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_pht[i] <= CNT_W'(cnt_rst(CNT_W));
        end else if (i_wr_en) begin
            r_pht[i_wr_idx] <= w_next;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// gshare conditional-branch direction predictor with speculative global
// history and commit-time recovery; HIST_W = 0 gives a bimodal table.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int HIST_W  = 4,
    parameter int CNT_W   = 2,
    localparam int HW     = (HIST_W > 0) ? HIST_W : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          rdy_in,
    input  logic          query_en,
    input  logic [31:0]   query_PC,
    output logic          result_out,
    output logic [HW-1:0] query_hist,
    input  logic          update_en,
    input  logic [31:0]   update_PC,
    input  logic          update_result,
    input  logic [HW-1:0] update_hist,
    input  logic          update_mispredict
);

    logic [31:0]        w_ghr_ext;
    logic [31:0]        w_uhist_ext;
    logic [INDEX_W-1:0] w_qidx;
    logic [INDEX_W-1:0] w_uidx;
    logic [CNT_W-1:0]   w_rd_cnt;
    logic               w_upd;

    assign w_upd  = rdy_in & update_en;
    assign w_qidx = INDEX_W'(fold_idx(query_PC,  w_ghr_ext,   INDEX_W));
    assign w_uidx = INDEX_W'(fold_idx(update_PC, w_uhist_ext, INDEX_W));

    generate
        if (HIST_W == 0) begin : g_bimodal
            logic w_unused_hist;
            assign w_unused_hist = &{1'b0, update_hist, update_mispredict, query_en};
            assign w_ghr_ext     = '0;
            assign w_uhist_ext   = '0;
            assign query_hist    = '0;
        end else begin : g_gshare
            logic [HW-1:0] r_ghr;
            assign w_ghr_ext   = 32'(r_ghr);
            assign w_uhist_ext = 32'(update_hist);
            assign query_hist  = r_ghr;

            // Mispredict repair wins over a same-cycle speculative shift.
            always_ff @(posedge clk_in) begin
                if (rst_in)
                    r_ghr <= '0;
                else if (rdy_in) begin
                    if (update_en && update_mispredict)
                        r_ghr <= HW'({update_hist, update_result});
                    else if (query_en)
                        r_ghr <= HW'({r_ghr, result_out});
                end
            end
        end
    endgenerate

    bp_pht #(
        .INDEX_W (INDEX_W),
        .CNT_W   (CNT_W)
    ) u_pht (
        .i_clk    (clk_in),
        .i_rst    (rst_in),
        .i_rd_idx (w_qidx),
        .o_rd_cnt (w_rd_cnt),
        .i_wr_en  (w_upd),
        .i_wr_idx (w_uidx),
        .i_wr_dir (update_result)
    );

    assign result_out = w_rd_cnt[CNT_W-1];

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench: a gshare instance (HIST_W=4) and a bimodal instance
// (HIST_W=0) share stimulus; vector table plus hand-written sequences.
module tb_gshare_predictor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        query_en;
    logic [31:0] query_PC;
    logic        update_en;
    logic [31:0] update_PC;
    logic        update_result;
    logic [3:0]  update_hist;
    logic        update_mispredict;
    logic        g_res, b_res;
    logic [3:0]  g_hist;
    logic [0:0]  b_hist;
    logic [0:0]  b_uhist = 1'b0;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk_in = ~clk_in;

    gshare_predictor #(.INDEX_W(6), .HIST_W(4), .CNT_W(2)) u_g (
        .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in),
        .query_en (query_en), .query_PC (query_PC),
        .result_out (g_res), .query_hist (g_hist),
        .update_en (update_en), .update_PC (update_PC),
        .update_result (update_result), .update_hist (update_hist),
        .update_mispredict (update_mispredict)
    );

    gshare_predictor #(.INDEX_W(6), .HIST_W(0), .CNT_W(2)) u_b (
        .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in),
        .query_en (query_en), .query_PC (query_PC),
        .result_out (b_res), .query_hist (b_hist),
        .update_en (update_en), .update_PC (update_PC),
        .update_result (update_result), .update_hist (b_uhist),
        .update_mispredict (update_mispredict)
    );

    typedef struct {
        logic        rdy;
        logic        qen;
        logic [31:0] qpc;
        logic        uen;
        logic [31:0] upc;
        logic        ures;
        logic [3:0]  uhist;
        logic        umis;
        logic        exp_rb;
        logic        exp_rg;
        logic [3:0]  exp_hg;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic rdy, input logic qen, input logic [31:0] qpc,
                         input logic uen, input logic [31:0] upc, input logic ures,
                         input logic [3:0] uh, input logic umis);
        rdy_in = rdy; query_en = qen; query_PC = qpc;
        update_en = uen; update_PC = upc; update_result = ures;
        update_hist = uh; update_mispredict = umis;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        //          rdy qen qpc        uen upc        res hist  mis  rb   rg   hg
        vt[0]  = '{1'b1,1'b0,32'h000,1'b0,32'h000,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[1]  = '{1'b1,1'b0,32'h07E,1'b0,32'h000,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[2]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[3]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[4]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[5]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[6]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b1,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[7]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b1,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[8]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b1,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[9]  = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b1,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[10] = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[11] = '{1'b1,1'b0,32'h100,1'b1,32'h100,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};
        vt[12] = '{1'b1,1'b0,32'h100,1'b0,32'h000,1'b0,4'h0,1'b0,1'b0,1'b0,4'h0};
        vt[13] = '{1'b0,1'b1,32'h102,1'b1,32'h102,1'b0,4'hA,1'b1,1'b1,1'b1,4'h0};
        vt[14] = '{1'b0,1'b1,32'h102,1'b1,32'h102,1'b0,4'hA,1'b1,1'b1,1'b1,4'h0};
        vt[15] = '{1'b1,1'b0,32'h102,1'b0,32'h000,1'b0,4'h0,1'b0,1'b1,1'b1,4'h0};

        do_reset();
        chk("rst_bimodal_hist", 32'(b_hist), 32'h0);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rdy, vt[i].qen, vt[i].qpc, vt[i].uen, vt[i].upc,
                  vt[i].ures, vt[i].uhist, vt[i].umis);
            #2;
            chk($sformatf("vec%0d_res_b", i), 32'(b_res),  32'(vt[i].exp_rb));
            chk($sformatf("vec%0d_res_g", i), 32'(g_res),  32'(vt[i].exp_rg));
            chk($sformatf("vec%0d_hist_g", i), 32'(g_hist), 32'(vt[i].exp_hg));
            @(negedge clk_in);
        end

        // Speculative shift: all predictions taken, history fills with ones.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
            #2;
            chk($sformatf("shift%0d_res", k), 32'(g_res), 32'h1);
            chk($sformatf("shift%0d_hist", k), 32'(g_hist), 32'((1 << k) - 1));
            @(negedge clk_in);
        end
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("shift_final_hist", 32'(g_hist), 32'hF);
        @(negedge clk_in);

        // Aliasing: ghr=0011 with PC 0x106 lands on entry 0.
        do_reset();
        drive(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        @(negedge clk_in);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("alias_hist", 32'(g_hist), 32'h3);
        chk("alias_res_pre", 32'(g_res), 32'h1);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h106, 1'b1, 32'h100, 1'b0, 4'h0, 1'b0);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("alias_res_post", 32'(g_res), 32'h0);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h106, 1'b1, 32'h140, 1'b0, 4'h0, 1'b1);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("recover_zero_hist", 32'(g_hist), 32'h0);
        chk("alias_pc100_res", 32'(g_res), 32'h0);
        @(negedge clk_in);

        // Recovery beats a same-cycle speculative shift.
        drive(1'b1, 1'b1, 32'h0, 1'b1, 32'h100, 1'b0, 4'hA, 1'b1);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("recover_prio_hist", 32'(g_hist), 32'h4);
        @(negedge clk_in);

        // Same-entry collision: query sees the pre-update counter.
        do_reset();
        drive(1'b1, 1'b1, 32'h104, 1'b1, 32'h104, 1'b0, 4'h0, 1'b0);
        #2;
        chk("collide_res_old", 32'(g_res), 32'h1);
        @(negedge clk_in);
        drive(1'b1, 1'b0, 32'h106, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("collide_hist", 32'(g_hist), 32'h1);
        chk("collide_res_new", 32'(g_res), 32'h0);
        @(negedge clk_in);

        // Reset lands even with rdy low and an update pending.
        rst_in = 1'b1;
        drive(1'b0, 1'b1, 32'h104, 1'b1, 32'h104, 1'b0, 4'h0, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b0;
        drive(1'b1, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 4'h0, 1'b0);
        #2;
        chk("midrst_hist", 32'(g_hist), 32'h0);
        chk("midrst_res_g", 32'(g_res), 32'h1);
        chk("midrst_res_b", 32'(b_res), 32'h1);
        @(negedge clk_in);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
